regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port register file for the pipelined MIPS core: NRD registered read
//  ports, two write ports with fixed priority, optional write-through bypass, optional
//  hardwired-zero register 0, and a per-register busy scoreboard for pending writes.
//  Sits between decode (reads and reserves) and writeback (two retire lanes).
// PARAMETERS
//  DW        32  data width in bits
//  AW        5   address width; depth = 2**AW registers
//  NRD       2   number of read ports (1..8)
//  ZERO_REG  1   1: reg 0 always reads 0, writes/reserves to it are dropped
//  BYPASS    1   1: same-cycle write data forwarded to read ports; 0: old contents returned
// PORTS
//  clk       in   1       clock, all state on rising edge
//  rst       in   1       synchronous reset, active-high
//  rd_en     in   NRD     per-port read enable; 0 = port output holds
//  rd_addr   in   NRD*AW  read addresses, port i at [i*AW +: AW]
//  rd_dout   out  NRD*DW  registered read data, port i at [i*DW +: DW]
//  rd_busy   out  NRD     registered busy bit of the addressed register
//  wa_wr     in   1       write port A enable (low priority)
//  wa_addr   in   AW      write port A address
//  wa_din    in   DW      write port A data
//  wb_wr     in   1       write port B enable (high priority)
//  wb_addr   in   AW      write port B address
//  wb_din    in   DW      write port B data
//  rsv_en    in   1       reserve: mark rsv_addr busy (write pending)
//  rsv_addr  in   AW      register to reserve
// BEHAVIOUR
//  - Reset (rst=1 at edge): all registers, busy bits, rd_dout, rd_busy -> 0. Reset beats
//    every other input; writes/reserves in a reset cycle are discarded.
//  - Write: at edge, port X with X_wr=1 updates reg[X_addr]. A and B to same address:
//    B's data stored. Address 0 with ZERO_REG=1: dropped.
//  - Read latency 1 cycle: rd_en[i]=1 at edge N -> rd_dout[i] valid after edge N.
//    Value = reg[rd_addr[i]] before edge N, unless BYPASS=1 and a write to that address
//    occurs at edge N: then the written data (B over A). ZERO_REG=1 and addr 0 -> 0 always.
//  - rd_en[i]=0: rd_dout[i] and rd_busy[i] hold their previous values.
//  - Busy: rsv_en sets busy[rsv_addr]; any write (A or B) clears busy[addr].
//    Reserve and write to same address in one cycle: busy stays 1 (new pending write wins).
//    Reserve of addr 0 with ZERO_REG=1 ignored; re-reserving a busy reg is legal (stays 1).
//  - rd_busy[i] samples busy state after this edge's updates (next-state value), so a
//    reading port sees a same-cycle clear or set consistently with bypassed data.
//  - Ports fully independent; any number of read ports may hit the same address.
//  - No X propagation: unused/out-of-range parameters are illegal, not handled.
// STRUCTURE
//  - regfile_pkg.vh: localparams for default DW/AW, ZERO_ADDR; shared by core pipeline.
//  - Sub-module regfile_rd_port (one per read port via generate): bypass mux, zero force,
//    enable-hold output register for dout and busy.
//  - Top holds storage array, write priority logic, busy vector.
// TESTING
//  1 Reset: write all regs, pulse rst one cycle -> every read returns 0, rd_busy=0.
//  2 Write A r5=0x1234_5678, next cycle read r5 on both ports -> 0x1234_5678 after 1 edge.
//  3 Same edge: wa r7=0xAAAA, wb r7=0xBBBB, rd r7 -> BYPASS=1: 0xBBBB; next read 0xBBBB;
//    BYPASS=0: first read old value 0, second read 0xBBBB.
//  4 Write r0=0xFFFF_FFFF, rsv r0 (ZERO_REG=1) -> read r0 = 0, rd_busy=0.
//  5 rsv r9 -> rd_busy=1; write r9 + rsv r9 same edge -> busy stays 1; write only -> 0.
//  6 rd_en[1]=0 while r3 rewritten -> rd_dout[1] holds old value; rd_en[1]=1 -> new value.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file and the core pipeline.
package regfile_mp_pkg;

  localparam int unsigned DefaultDw = 32;
  localparam int unsigned DefaultAw = 5;
  localparam int unsigned ZeroAddr  = 0;

endpackage

// File: rtl/regfile_mp_rd_port.sv
// One registered read port: bypass mux, register-0 force and enable-hold output stage.
module regfile_mp_rd_port
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DW       = DefaultDw,
  parameter int unsigned AW       = DefaultAw,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] mem_data,
  input  logic          busy_next,
  input  logic          wa_en,
  input  logic [AW-1:0] wa_addr,
  input  logic [DW-1:0] wa_din,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_din,
  output logic [DW-1:0] rd_dout,
  output logic          rd_busy
);

  logic [DW-1:0] rdata;
  logic [DW-1:0] dout_d, dout_q;
  logic          busy_d, busy_q;

  // Select stored or forwarded data (B beats A), then hold when the port is idle.
  always_comb begin
    rdata = mem_data;
    if (BYPASS != 0) begin
      if (wa_en && (wa_addr == rd_addr)) rdata = wa_din;
      if (wb_en && (wb_addr == rd_addr)) rdata = wb_din;
    end
    if ((ZERO_REG != 0) && (rd_addr == AW'(ZeroAddr))) rdata = '0;
    dout_d = rd_en ? rdata : dout_q;
    busy_d = rd_en ? busy_next : busy_q;
  end

  // Output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
      busy_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      busy_q <= busy_d;
    end
  end

  assign rd_dout = dout_q;
  assign rd_busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage, two prioritised write lanes, busy scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DW       = DefaultDw,
  parameter int unsigned AW       = DefaultAw,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_dout,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wa_wr,
  input  logic [AW-1:0]     wa_addr,
  input  logic [DW-1:0]     wa_din,
  input  logic              wb_wr,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DW-1:0]     wb_din,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0]    mem_d [Depth];
  logic [DW-1:0]    mem_q [Depth];
  logic [Depth-1:0] busy_d, busy_q;
  logic             wa_en, wb_en, rsv_ok;

  // Writes and reserves aimed at the hardwired zero register are dropped here.
  always_comb begin
    wa_en  = wa_wr  && !((ZERO_REG != 0) && (wa_addr  == AW'(ZeroAddr)));
    wb_en  = wb_wr  && !((ZERO_REG != 0) && (wb_addr  == AW'(ZeroAddr)));
    rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == AW'(ZeroAddr)));
  end

  // Next state: A then B so B wins a collision; reserve applied last so it wins over a clear.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wa_en) begin
      mem_d[wa_addr]  = wa_din;
      busy_d[wa_addr] = 1'b0;
    end
    if (wb_en) begin
      mem_d[wb_addr]  = wb_din;
      busy_d[wb_addr] = 1'b0;
    end
    if (rsv_ok) busy_d[rsv_addr] = 1'b1;
  end

  // Storage and busy vector with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[p*AW +: AW];

    regfile_mp_rd_port #(
      .DW      (DW),
      .AW      (AW),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_port (
      .clk      (clk),
      .rst      (rst),
      .rd_en    (rd_en[p]),
      .rd_addr  (addr),
      .mem_data (mem_q[addr]),
      .busy_next(busy_d[addr]),
      .wa_en    (wa_en),
      .wa_addr  (wa_addr),
      .wa_din   (wa_din),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .wb_din   (wb_din),
      .rd_dout  (rd_dout[p*DW +: DW]),
      .rd_busy  (rd_busy[p])
    );
  end

endmodule
